// File: rtl/spi_slave_pkg.sv
// Shared types and idle line levels for the SPI slave.
package spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with one-entry TX buffer and one-entry RX register.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_sck,
    input  logic          spi_cs,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          rx_ovf,
    output logic          tx_unf,
    output logic          busy
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    logic sck_s, cs_s, mosi_s;
    logic sck_prev, cs_prev;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    logic [SYNC_STAGES:0] settle;
    logic                 armed;

    state_t state, state_next;

    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] rx_shift;
    logic [DW-1:0] tx_shift;
    logic [DW-1:0] tx_buf;
    logic          tx_full;
    logic          reload_pending;
    logic          word_done;

    logic active, start, bit_rise, bit_fall, tx_load, tx_write;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sync_sck (
        .clk(clk), .rst(rst), .d(spi_sck), .q(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
    );

    // A cs held low through reset only looks like a falling edge once the
    // synchronizer drains, so starts are accepted only after cs is seen idle.
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = armed & cs_prev & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev;

    assign active   = (state == ACTIVE);
    assign start    = (state == IDLE) && cs_fall;
    assign bit_rise = active && !cs_rise && sck_rise;
    assign bit_fall = active && !cs_rise && sck_fall;
    assign tx_load  = start || (bit_fall && reload_pending);
    assign tx_write = tx_valid && tx_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev       <= SCK_IDLE;
            cs_prev        <= CS_IDLE;
            settle         <= '0;
            armed          <= 1'b0;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            tx_buf         <= '0;
            tx_full        <= 1'b0;
            reload_pending <= 1'b0;
            word_done      <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_ovf         <= 1'b0;
            tx_unf         <= 1'b0;
        end else begin
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
            word_done <= 1'b0;
            rx_ovf    <= 1'b0;
            tx_unf    <= 1'b0;

            if (settle[SYNC_STAGES] && cs_s) armed <= 1'b1;

            if (start || (active && cs_rise)) begin
                bit_cnt        <= '0;
                rx_shift       <= '0;
                reload_pending <= 1'b0;
            end else if (bit_rise) begin
                rx_shift <= (rx_shift << 1) | DW'(mosi_s);
                if (bit_cnt == CW'(DW - 1)) begin
                    bit_cnt        <= '0;
                    word_done      <= 1'b1;
                    reload_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_fall) begin
                reload_pending <= 1'b0;
            end

            if (tx_load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                end else begin
                    tx_shift <= '1;
                    tx_unf   <= 1'b1;
                end
            end else if (bit_fall) begin
                tx_shift <= tx_shift << 1;
            end

            tx_full <= (tx_full && !tx_load) || tx_write;
            if (tx_write) tx_buf <= tx_data;

            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_ovf <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy     = active;
    assign tx_ready = !tx_full;
    assign spi_miso = active & tx_shift[DW-1];

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 master model drives the SPI pins.
module tb_spi_slave;

    localparam int unsigned DW   = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_sck, spi_cs, spi_mosi, spi_miso;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ready, rx_ovf, tx_unf, busy;

    int vectors     = 0;
    int miscompares = 0;
    int ovf_cnt     = 0;
    int unf_cnt     = 0;
    int rxv_rise    = 0;
    logic rxv_d     = 1'b0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] miso_q[$];

    spi_slave #(.SYNC_STAGES(SYNC), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_ovf(rx_ovf), .tx_unf(tx_unf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Accepted RX words are checked against the scoreboard at the handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ovf) ovf_cnt++;
            if (tx_unf) unf_cnt++;
            if (rx_valid && !rxv_d) rxv_rise++;
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) check("rx_extra_word", 32'(rx_q.size()), 32'd1);
                else                  check("rx_word", rx_data, rx_q.pop_front());
            end
        end
        rxv_d = rx_valid;
    end

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_cs = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic xfer(input logic [DW-1:0] mosi_word, input int nbits,
                        input bit ready_pulse, output logic [DW-1:0] miso_word);
        miso_word = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_word[DW-1-i];
            tick(HALF);
            spi_sck   = 1'b1;
            miso_word = {miso_word[DW-2:0], spi_miso};
            if (ready_pulse && i == nbits - 1) begin
                tick(SYNC + 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                tick(HALF - SYNC - 2);
            end else begin
                tick(HALF);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic tx_push(input logic [DW-1:0] v, input bit track);
        int n = 0;
        while (!tx_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!tx_ready) check("tx_ready_timeout", tx_ready, 1);
        tx_data  = v;
        tx_valid = 1'b1;
        if (track) miso_q.push_back(v);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic miso_check(input logic [DW-1:0] got);
        if (miso_q.size() == 0) check("miso_no_expect", 32'(miso_q.size()), 32'd1);
        else                    check("miso_word", got, miso_q.pop_front());
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (rx_q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        check("rx_drain", 32'(rx_q.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] m;
        int o0, u0, v0;

        rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        tick(3);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_ovf", rx_ovf, 0);
        check("rst_tx_unf", tx_unf, 0);
        rst = 1'b0;
        tick(SYNC + 4);
        check("idle_busy", busy, 0);

        // basic word: A5 out, 3C in
        rx_ready = 1'b1;
        tx_push(8'hA5, 1);
        check("tx_full_ready", tx_ready, 0);
        cs_low();
        check("busy_active", busy, 1);
        check("tx_load_empties", tx_ready, 1);
        rx_q.push_back(8'h3C);
        xfer(8'h3C, DW, 0, m);
        miso_check(m);
        cs_high();
        check("busy_idle", busy, 0);
        drain(50);

        // back-to-back words with a refill after the first load
        tx_push(8'h5A, 1);
        cs_low();
        tx_push(8'h33, 1);
        rx_q.push_back(8'h11);
        xfer(8'h11, DW, 0, m);
        miso_check(m);
        rx_q.push_back(8'h22);
        xfer(8'h22, DW, 0, m);
        miso_check(m);
        cs_high();
        drain(50);

        // overflow: second word dropped while first is held
        rx_ready = 1'b0;
        o0 = ovf_cnt;
        cs_low();
        xfer(8'h55, DW, 0, m);
        xfer(8'h66, DW, 0, m);
        cs_high();
        check("ovf_keep_data", rx_data, 8'h55);
        check("ovf_keep_valid", rx_valid, 1);
        check("ovf_pulses", 32'(ovf_cnt - o0), 1);
        rx_q.push_back(8'h55);
        rx_ready = 1'b1;
        tick(3);
        rx_ready = 1'b0;
        check("ovf_consumed", rx_valid, 0);

        // replace: consumer accepts in the very cycle the new word lands
        cs_low();
        xfer(8'h55, DW, 0, m);
        check("rx_hold", rx_valid, 1);
        o0 = ovf_cnt;
        rx_q.push_back(8'h55);
        xfer(8'h66, DW, 1, m);
        cs_high();
        check("replace_data", rx_data, 8'h66);
        check("replace_valid", rx_valid, 1);
        check("replace_no_ovf", 32'(ovf_cnt - o0), 0);
        rx_q.push_back(8'h66);
        rx_ready = 1'b1;
        drain(50);

        // underflow at cs fall
        check("tx_empty", tx_ready, 1);
        u0 = unf_cnt;
        miso_q.push_back(8'hFF);
        cs_low();
        tx_push(8'h77, 0);
        rx_q.push_back(8'h00);
        xfer(8'h00, DW, 0, m);
        miso_check(m);
        cs_high();
        check("unf_pulses", 32'(unf_cnt - u0), 1);
        drain(50);

        // partial word aborted by cs, then a full word
        v0 = rxv_rise;
        cs_low();
        xfer(8'hFF, 5, 0, m);
        cs_high();
        check("partial_no_valid", 32'(rxv_rise - v0), 0);
        rx_q.push_back(8'h81);
        cs_low();
        xfer(8'h81, DW, 0, m);
        cs_high();
        drain(50);
        check("rx_data_81", rx_data, 8'h81);

        // reset mid-word, cs still low afterwards
        cs_low();
        xfer(8'hAA, 3, 0, m);
        rst = 1'b1;
        tick(1);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_ovf", rx_ovf, 0);
        check("mid_rst_tx_unf", tx_unf, 0);
        rst = 1'b0;
        tick(2 * HALF);
        check("no_spurious_start", busy, 0);
        spi_cs = 1'b1;
        tick(2 * HALF);
        rx_q.push_back(8'hC3);
        cs_low();
        xfer(8'hC3, DW, 0, m);
        cs_high();
        drain(50);

        check("miso_q_empty", 32'(miso_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameters: SYNC_STAGES, default 2, synchronizer depth for the SPI inputs; DW, default 8, SPI word width.
REQ-002 Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset, synchronous and active-high.
- spi_sck  input  1  SPI clock from the master, asynchronous to clk.
- spi_cs  input  1  active-low chip select from the master.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- tx_data  input  DW  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX buffer can accept a word.
- rx_data  output  DW  received word.
- rx_valid  output  1  rx_data is valid.
- rx_ready  input  1  consumer accepts rx_data.
- rx_ovf  output  1  one-cycle pulse: received word dropped.
- tx_unf  output  1  one-cycle pulse: TX buffer empty at load.
- busy  output  1  synchronized chip select is active.

Function
REQ-003 The block SHALL pass spi_sck, spi_cs and spi_mosi through SYNC_STAGES flops, then edge-detect the synchronized sck and cs against their previous-cycle values.
REQ-004 Operation SHALL be SPI mode 0 only (CPOL=0, CPHA=0), MSB first; clk SHALL be at least 8x the spi_sck frequency.
REQ-005 The FSM SHALL have two states: IDLE (cs inactive) and ACTIVE; a cs falling edge moves IDLE->ACTIVE, and a cs rising edge moves ACTIVE->IDLE.
REQ-006 On IDLE->ACTIVE: bit counter <= 0, and the TX shift register is loaded from the TX buffer.
REQ-007 On each synchronized sck rising edge in ACTIVE: shift the synchronized mosi into the RX shift register LSB and increment the bit counter.
REQ-008 When the bit counter reaches DW: the assembled word SHALL be offered to the RX register in the following clk cycle, and the counter SHALL wrap to 0.
REQ-009 On each synchronized sck falling edge in ACTIVE: shift the TX register left, except after the DW-th bit, when the TX register is reloaded from the TX buffer.
REQ-010 spi_miso SHALL equal TX register MSB while ACTIVE, and 0 while IDLE.
REQ-011 TX buffer: one entry; tx_ready = !full; a write occurs when tx_valid && tx_ready; the buffer empties when loaded into the TX register.
REQ-012 Load with an empty TX buffer: the TX register SHALL load all-ones and tx_unf SHALL pulse for 1 cycle.
REQ-013 Load and tx write in the same cycle: the buffer stays full, holding the new word; the old word goes to the TX register.
REQ-014 RX register: rx_valid SHALL hold until rx_valid && rx_ready; rx_data SHALL be stable while rx_valid is high.
REQ-015 New word arriving with rx_valid=1 and rx_ready=0: the new word SHALL be dropped, the old word kept, and rx_ovf SHALL pulse for 1 cycle.
REQ-016 New word arriving with rx_valid=1 and rx_ready=1 in the same cycle: the new word SHALL replace the old one, rx_valid stays 1, and there is no rx_ovf.
REQ-017 cs rising mid-word: the partial RX word SHALL be discarded with no rx_valid; the TX register content is lost (not returned to the buffer); the bit counter is reset to 0.
REQ-018 busy SHALL be 1 exactly while the FSM is in ACTIVE.

Reset
REQ-019 While rst=1 at a clk edge: FSM=IDLE; counters, shift registers, TX buffer, rx_data = 0; rx_valid, rx_ovf, tx_unf, busy, spi_miso = 0; tx_ready = 1.
REQ-020 Synchronizer flops SHALL reset to idle line values: sck=0, cs=1, mosi=0; no edge SHALL be detected in the first cycle after reset.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer; the block SHALL wait for a fresh cs falling edge.

Structure
REQ-022 Package spi_slave_pkg SHALL hold the FSM state enum and the idle line-level constants.
REQ-023 Sub-module spi_sync SHALL be a parameterized SYNC_STAGES flop chain with a reset value, instantiated once per SPI input.

Verification
REQ-024 tx 0xA5 preloaded; master sends 0x3C in mode 0 -> master receives 0xA5; rx_data=0x3C with one rx_valid; tx_ready returns to 1.
REQ-025 Two back-to-back words 0x11, 0x22 under one cs, rx_ready=1, TX buffer refilled with 0x33 after the first load -> rx sees 0x11 then 0x22; miso carries 0x33 in word 2.
REQ-026 rx_ready=0; send 0x55 then 0x66 -> rx_data stays 0x55, one rx_ovf pulse; same test with rx_ready=1 on the arrival cycle -> rx_data=0x66, no rx_ovf.
REQ-027 Empty TX buffer at cs fall -> miso=0xFF for that word; tx_unf pulses once.
REQ-028 cs deasserted after 5 sck edges, then a full 0x81 transfer -> no rx_valid for the partial word; rx_data=0x81.
REQ-029 rst pulsed mid-word -> all outputs equal reset values next cycle; the next full transfer of 0xC3 is received correctly.
